nic_wb_slave_packetizer: RTL and testbench

// Next-generation NIC Wishbone slave front end. Accepts pipelined WB bursts, buffers up to MAX_BEATS beats, and packetizes each

---
 rtl/nic_wb_slave_packetizer.sv | 215 +++++++++++++++++++++
 tb/tb_nic_wb_slave_packetizer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_wb_slave_packetizer.sv
// Wishbone slave front end of the NIC: buffers write bursts and read requests and
// emits each message as head/body/tail flits on a valid/ready NoC-side port.
module nic_wb_slave_packetizer #(
  parameter int DAT_W           = 32,
  parameter int ADR_W           = 32,
  parameter int FLIT_W          = 64,
  parameter int MAX_BEATS       = 8,
  parameter int N_BITS_BEATS    = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int N_BITS_OUTST    = 3,
  parameter int N_BITS_NODE     = 4,
  parameter int NODE_ID         = 0,
  parameter int N_BITS_VNET_ID  = 2,
  parameter int VNET_WR         = 0,
  parameter int VNET_RD         = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      CYC_I,
  input  logic                      STB_I,
  input  logic                      WE_I,
  input  logic [2:0]                CTI_I,
  input  logic [ADR_W-1:0]          ADR_I,
  input  logic [DAT_W-1:0]          DAT_I,
  input  logic [DAT_W/8-1:0]        SEL_I,
  output logic                      ACK_O,
  output logic                      ERR_O,
  output logic                      STALL_O,
  output logic                      RTY_O,
  output logic [FLIT_W-1:0]         flit_o,
  output logic [N_BITS_VNET_ID-1:0] flit_vnet_o,
  output logic                      flit_valid_o,
  input  logic                      flit_ready_i,
  input  logic                      rd_done_i,
  output logic [N_BITS_OUTST-1:0]   outstanding_o
);

  localparam int BEAT_W    = DAT_W + DAT_W / 8;
  localparam int IDX_W     = $clog2(MAX_BEATS);
  localparam int HDR_FIX_W = 2 * N_BITS_NODE + 1 + N_BITS_BEATS + N_BITS_VNET_ID;
  localparam int HADR_W    = FLIT_W - 2 - HDR_FIX_W;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COLLECT   = 3'd1;
  localparam logic [2:0] S_SEND_HEAD = 3'd2;
  localparam logic [2:0] S_SEND_BODY = 3'd3;
  localparam logic [2:0] S_ERR_DRAIN = 3'd4;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [N_BITS_BEATS-1:0]   BEATS_MAX = N_BITS_BEATS'(MAX_BEATS);
  localparam logic [N_BITS_OUTST-1:0]   OUTST_MAX = N_BITS_OUTST'(MAX_OUTSTANDING);
  localparam logic [N_BITS_NODE-1:0]    SRC_ID    = N_BITS_NODE'(NODE_ID);
  localparam logic [N_BITS_VNET_ID-1:0] VNET_W_C  = N_BITS_VNET_ID'(VNET_WR);
  localparam logic [N_BITS_VNET_ID-1:0] VNET_R_C  = N_BITS_VNET_ID'(VNET_RD);

  logic [2:0]                state;
  logic [N_BITS_BEATS-1:0]   count;
  logic [N_BITS_BEATS-1:0]   idx;
  logic [ADR_W-1:0]          adr;
  logic                      we;
  logic [N_BITS_OUTST-1:0]   outstanding;
  logic [BEAT_W-1:0]         beat_buf [MAX_BEATS];

  logic                      stall;
  logic                      accept;
  logic                      err_cond;
  logic                      store;
  logic [IDX_W-1:0]          wr_ptr;
  logic                      last_beat;
  logic                      rd_inc;
  logic                      rd_dec;
  logic [N_BITS_NODE-1:0]    dest;
  logic [N_BITS_VNET_ID-1:0] vnet_cur;
  logic [HADR_W-1:0]         adr_field;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    stall = 1'b1;
    case (state)
      S_IDLE:                 stall = !WE_I && (outstanding == OUTST_MAX);
      S_COLLECT, S_ERR_DRAIN: stall = 1'b0;
      default:                stall = 1'b1;
    endcase
  end

  // Reset must also hold off the master while rst_n is low.
  assign STALL_O   = stall | !rst_n;
  assign RTY_O     = 1'b0;
  assign accept    = CYC_I && STB_I && !STALL_O;
  assign err_cond  = (state == S_ERR_DRAIN) || ((state == S_COLLECT) && (count == BEATS_MAX));
  assign store     = accept && (((state == S_IDLE) && WE_I) ||
                                ((state == S_COLLECT) && (count != BEATS_MAX)));
  assign wr_ptr    = (state == S_IDLE) ? '0 : count[IDX_W-1:0];
  assign last_beat = (idx == count - 1'b1);
  assign rd_inc    = (state == S_SEND_HEAD) && !we && flit_ready_i;
  assign rd_dec    = rd_done_i && (outstanding != '0);
  assign dest      = adr[ADR_W-1 -: N_BITS_NODE];
  assign vnet_cur  = we ? VNET_W_C : VNET_R_C;
  assign adr_field = HADR_W'(adr);

  assign flit_valid_o  = (state == S_SEND_HEAD) || (state == S_SEND_BODY);
  assign outstanding_o = outstanding;

  always_comb begin
    flit_o      = '0;
    flit_vnet_o = '0;
    case (state)
      S_SEND_HEAD: begin
        flit_o[HDR_FIX_W-1:0]        = {vnet_cur, count, we, SRC_ID, dest};
        flit_o[FLIT_W-3:HDR_FIX_W]   = adr_field;
        flit_o[FLIT_W-1 -: 2]        = we ? T_HEAD : T_HT;
        flit_vnet_o                  = vnet_cur;
      end
      S_SEND_BODY: begin
        flit_o[BEAT_W-1:0]    = beat_buf[idx[IDX_W-1:0]];
        flit_o[FLIT_W-1 -: 2] = last_beat ? T_TAIL : T_BODY;
        flit_vnet_o           = VNET_W_C;
      end
      default: ;
    endcase
  end

  // NOTE: the beat buffer is storage, not control; it is never reset, only the count that qualifies it.
  always_ff @(posedge clk) begin
    if (store) beat_buf[wr_ptr] <= {SEL_I, DAT_I};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
      idx   <= '0;
      adr   <= '0;
      we    <= 1'b0;
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
    end else begin
      ACK_O <= accept && !err_cond && ((state != S_IDLE) || WE_I);
      ERR_O <= accept && err_cond;
      case (state)
        S_IDLE: begin
          if (accept) begin
            adr   <= ADR_I;
            we    <= WE_I;
            count <= N_BITS_BEATS'(1);
            idx   <= '0;
            if (WE_I && (CTI_I != CTI_CLASSIC) && (CTI_I != CTI_END)) state <= S_COLLECT;
            else                                                      state <= S_SEND_HEAD;
          end
        end
        S_COLLECT: begin
          if (!CYC_I) begin
            state <= S_IDLE;
            count <= '0;
          end else if (accept) begin
            if (count == BEATS_MAX) begin
              state <= S_ERR_DRAIN;
              count <= '0;
            end else begin
              count <= count + 1'b1;
              if (CTI_I == CTI_END) state <= S_SEND_HEAD;
            end
          end
        end
        S_SEND_HEAD: begin
          if (flit_ready_i) begin
            idx <= '0;
            if (we) begin
              state <= S_SEND_BODY;
            end else begin
              state <= S_IDLE;
              count <= '0;
            end
          end
        end
        S_SEND_BODY: begin
          if (flit_ready_i) begin
            if (last_beat) begin
              state <= S_IDLE;
              count <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_ERR_DRAIN: begin
          if (!CYC_I) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A read counts as in flight from the moment its head-tail flit leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({rd_inc, rd_dec})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_wb_slave_packetizer.sv
// Self-checking bench for nic_wb_slave_packetizer: directed scenarios plus a
// randomized mix, all compared against a flit-level model of the message format.
module tb_nic_wb_slave_packetizer;

  localparam int MAX_OUT = 4;
  localparam int NODE_ID = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CYC_I, STB_I, WE_I;
  logic [2:0]  CTI_I;
  logic [31:0] ADR_I, DAT_I;
  logic [3:0]  SEL_I;
  logic        ACK_O, ERR_O, STALL_O, RTY_O;
  logic [63:0] flit_o;
  logic [1:0]  flit_vnet_o;
  logic        flit_valid_o, flit_ready_i, rd_done_i;
  logic [2:0]  outstanding_o;

  logic        ready_ctl = 1'b1;
  logic        rand_ready_en = 1'b0;
  logic        rnd_bit = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  logic [65:0] got_q[$];
  logic [65:0] exp_q[$];
  logic [31:0] bdat[16];
  logic [3:0]  bsel[16];

  nic_wb_slave_packetizer dut (
    .clk(clk), .rst_n(rst_n),
    .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .CTI_I(CTI_I),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I),
    .ACK_O(ACK_O), .ERR_O(ERR_O), .STALL_O(STALL_O), .RTY_O(RTY_O),
    .flit_o(flit_o), .flit_vnet_o(flit_vnet_o), .flit_valid_o(flit_valid_o),
    .flit_ready_i(flit_ready_i), .rd_done_i(rd_done_i), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  assign flit_ready_i = rand_ready_en ? rnd_bit : ready_ctl;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Inputs change just after posedge; the handshake seen here completes on the next posedge.
  always @(negedge clk) begin
    if (flit_valid_o && flit_ready_i) got_q.push_back({flit_vnet_o, flit_o});
    if (ACK_O) ack_cnt++;
    if (ERR_O) err_cnt++;
  end

  function automatic logic [65:0] m_head(input logic [31:0] adr, input logic we, input int len);
    logic [63:0] f;
    logic [1:0]  vnet;
    vnet = we ? 2'd0 : 2'd1;
    f = 64'(adr[31:28]) + (64'(NODE_ID) << 4) + (64'(we) << 8) + (64'(len) << 9) +
        (64'(vnet) << 13) + (64'(adr) << 15);
    f[63:62] = we ? 2'b01 : 2'b11;
    return {vnet, f};
  endfunction

  function automatic logic [65:0] m_data(input logic [31:0] dat, input logic [3:0] sel, input logic last);
    logic [63:0] f;
    f = (64'(sel) << 32) + 64'(dat);
    f[63:62] = last ? 2'b10 : 2'b00;
    return {2'b00, f};
  endfunction

  task automatic clear_logs;
    got_q.delete();
    exp_q.delete();
    ack_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic drive_beat(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [2:0] cti, output bit ok);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat; SEL_I = sel; CTI_I = cti;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!STALL_O) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    STB_I = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL beat_accept_timeout adr %h: STALL_O still %b, want 0", adr, STALL_O);
    end
  endtask

  task automatic wb_burst(input logic we, input logic [31:0] adr, input int n);
    bit ok;
    logic [2:0] cti;
    for (int i = 0; i < n; i++) begin
      cti = (n == 1) ? 3'b000 : (i == n - 1) ? 3'b111 : 3'b010;
      drive_beat(we, adr + 32'(4 * i), bdat[i], bsel[i], cti, ok);
    end
    CYC_I = 1'b0;
  endtask

  task automatic fill_beats(input int n);
    for (int i = 0; i < n; i++) begin
      bdat[i] = $urandom;
      bsel[i] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic model_write(input logic [31:0] adr, input int n);
    exp_q.push_back(m_head(adr, 1'b1, n));
    for (int i = 0; i < n; i++) exp_q.push_back(m_data(bdat[i], bsel[i], i == n - 1));
  endtask

  task automatic wait_flits(input int n, input string tag);
    for (int c = 0; c < 400 && got_q.size() < n; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    if (got_q.size() < n) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_flit_timeout got %0d flits, want %0d", tag, got_q.size(), n);
    end
  endtask

  task automatic wait_idle;
    for (int c = 0; c < 400 && flit_valid_o; c++) begin
      @(posedge clk); #1;
    end
    if (flit_valid_o) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout flit_valid_o still 1, want 0");
    end
  endtask

  task automatic pulse_done;
    rd_done_i = 1'b1;
    @(posedge clk); #1;
    rd_done_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; CTI_I = 3'b000;
    ADR_I = '0; DAT_I = '0; SEL_I = '0; rd_done_i = 1'b0; ready_ctl = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (STALL_O !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b want 1", STALL_O); end
    n_cmp++; if (ACK_O !== 1'b0 || ERR_O !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err got %b%b want 00", ACK_O, ERR_O); end
    n_cmp++; if (flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", flit_valid_o); end
    n_cmp++; if (flit_o !== 64'd0) begin n_fail++; $display("FAIL reset_flit got %h want 0", flit_o); end
    n_cmp++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding got %0d want 0", outstanding_o); end
    n_cmp++; if (RTY_O !== 1'b0) begin n_fail++; $display("FAIL reset_rty got %b want 0", RTY_O); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (STALL_O !== 1'b0) begin n_fail++; $display("FAIL idle_stall got %b want 0", STALL_O); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write;
    bit ok;
    clear_logs();
    ready_ctl = 1'b1;
    drive_beat(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, ok);
    CYC_I = 1'b0;
    n_cmp++; if (ACK_O !== 1'b1) begin n_fail++; $display("FAIL single_ack_next_cycle got %b want 1", ACK_O); end
    exp_q.push_back(m_head(32'h3000_0010, 1'b1, 1));
    exp_q.push_back(m_data(32'hDEAD_BEEF, 4'hF, 1'b1));
    wait_flits(2, "single");
    n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL single_count got %0d want 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_flit[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : 66'hx, exp_q[i]);
      end
    end
    n_cmp++; if (ack_cnt != 1) begin n_fail++; $display("FAIL single_ack_count got %0d want 1", ack_cnt); end
  endtask

  task automatic test_burst;
    logic [31:0] adr;
    clear_logs();
    ready_ctl = 1'b1;
    fill_beats(4);
    adr = $urandom & 32'hF00F_FFF0;
    model_write(adr, 4);
    wb_burst(1'b1, adr, 4);
    wait_flits(5, "burst");
    n_cmp++; if (got_q.size() != 5) begin n_fail++; $display("FAIL burst_count got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL burst_flit[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : 66'hx, exp_q[i]);
      end
    end
    n_cmp++; if (ack_cnt != 4 || err_cnt != 0) begin n_fail++; $display("FAIL burst_acks got %0d/%0d want 4/0", ack_cnt, err_cnt); end
  endtask

  task automatic test_backpressure;
    logic [31:0] adr;
    logic [63:0] snap;
    clear_logs();
    ready_ctl = 1'b0;
    fill_beats(4);
    adr = $urandom & 32'hF00F_FFF0;
    model_write(adr, 4);
    wb_burst(1'b1, adr, 4);
    ready_ctl = 1'b1;
    for (int c = 0; c < 50 && got_q.size() < 2; c++) begin
      @(posedge clk); #1;
    end
    ready_ctl = 1'b0;
    snap = flit_o;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (flit_o !== snap || flit_valid_o !== 1'b1 || STALL_O !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold got flit %h valid %b stall %b want %h 1 1", flit_o, flit_valid_o, STALL_O, snap);
      end
    end
    @(posedge clk); #1;
    ready_ctl = 1'b1;
    wait_flits(5, "bp");
    n_cmp++; if (got_q.size() != 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_flit[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : 66'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow;
    clear_logs();
    ready_ctl = 1'b1;
    fill_beats(10);
    wb_burst(1'b1, $urandom & 32'hF00F_FFF0, 10);
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (ack_cnt != 8) begin n_fail++; $display("FAIL ovf_acks got %0d want 8", ack_cnt); end
    n_cmp++; if (err_cnt != 2) begin n_fail++; $display("FAIL ovf_errs got %0d want 2", err_cnt); end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL ovf_no_flits got %0d want 0", got_q.size()); end
  endtask

  task automatic test_reads;
    bit ok;
    logic [31:0] adr;
    clear_logs();
    ready_ctl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adr = $urandom;
      exp_q.push_back(m_head(adr, 1'b0, 1));
      drive_beat(1'b0, adr, 32'd0, 4'd0, 3'b000, ok);
    end
    CYC_I = 1'b0;
    wait_flits(4, "reads");
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL read_flit[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : 66'hx, exp_q[i]);
      end
    end
    n_cmp++; if (outstanding_o !== 3'd4) begin n_fail++; $display("FAIL read_outstanding got %0d want 4", outstanding_o); end
    n_cmp++; if (ack_cnt != 0) begin n_fail++; $display("FAIL read_no_ack got %0d want 0", ack_cnt); end
    adr = $urandom;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = adr; CTI_I = 3'b000;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (STALL_O !== 1'b1) begin n_fail++; $display("FAIL read_limit_stall got %b want 1", STALL_O); end
    end
    @(posedge clk); #1;
    pulse_done();
    exp_q.push_back(m_head(adr, 1'b0, 1));
    drive_beat(1'b0, adr, 32'd0, 4'd0, 3'b000, ok);
    CYC_I = 1'b0;
    wait_flits(5, "read5");
    n_cmp++;
    if (got_q.size() != 5 || got_q[4] !== exp_q[4]) begin
      n_fail++; $display("FAIL read5_flit got %0d flits last %h want 5 flits last %h", got_q.size(), (got_q.size() > 0) ? got_q[got_q.size()-1] : 66'hx, exp_q[4]);
    end
    n_cmp++; if (outstanding_o !== 3'd4) begin n_fail++; $display("FAIL read5_outstanding got %0d want 4", outstanding_o); end
  endtask

  task automatic test_rd_done_coincide;
    bit ok;
    clear_logs();
    pulse_done();
    pulse_done();
    n_cmp++; if (outstanding_o !== 3'd2) begin n_fail++; $display("FAIL done_dec got %0d want 2", outstanding_o); end
    ready_ctl = 1'b0;
    drive_beat(1'b0, $urandom, 32'd0, 4'd0, 3'b000, ok);
    CYC_I = 1'b0;
    ready_ctl = 1'b1;
    rd_done_i = 1'b1;
    @(posedge clk); #1;
    rd_done_i = 1'b0;
    n_cmp++; if (outstanding_o !== 3'd2) begin n_fail++; $display("FAIL coincide got %0d want 2", outstanding_o); end
    n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL coincide_flits got %0d want 1", got_q.size()); end
    repeat (3) pulse_done();
    n_cmp++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL done_at_zero got %0d want 0", outstanding_o); end
  endtask

  task automatic test_reset_mid_body;
    clear_logs();
    ready_ctl = 1'b0;
    fill_beats(4);
    wb_burst(1'b1, $urandom & 32'hF00F_FFF0, 4);
    ready_ctl = 1'b1;
    @(posedge clk); #1;
    ready_ctl = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (flit_valid_o !== 1'b0 || flit_o !== 64'd0) begin n_fail++; $display("FAIL rst_mid_body got valid %b flit %h want 0 0", flit_valid_o, flit_o); end
    got_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_ctl = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_no_partial got %0d flits want 0", got_q.size()); end
  endtask

  task automatic test_random;
    bit ok;
    int n, model_out, exp_acks;
    logic [31:0] adr;
    clear_logs();
    model_out = 0;
    exp_acks = 0;
    rand_ready_en = 1'b1;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        if (model_out == MAX_OUT) begin
          wait_idle();
          pulse_done();
          model_out--;
        end
        adr = $urandom;
        exp_q.push_back(m_head(adr, 1'b0, 1));
        drive_beat(1'b0, adr, 32'd0, 4'd0, 3'b000, ok);
        CYC_I = 1'b0;
        model_out++;
      end else begin
        n = $urandom_range(1, 8);
        fill_beats(n);
        adr = $urandom & 32'hF00F_FFF0;
        model_write(adr, n);
        wb_burst(1'b1, adr, n);
        exp_acks += n;
      end
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        pulse_done();
        if (model_out > 0) model_out--;
      end
    end
    wait_flits(exp_q.size(), "rand");
    rand_ready_en = 1'b0;
    ready_ctl = 1'b1;
    wait_idle();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_flit[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : 66'hx, exp_q[i]);
      end
    end
    n_cmp++; if (ack_cnt != exp_acks) begin n_fail++; $display("FAIL rand_acks got %0d want %0d", ack_cnt, exp_acks); end
    n_cmp++; if (outstanding_o !== 3'(model_out)) begin n_fail++; $display("FAIL rand_outstanding got %0d want %0d", outstanding_o, model_out); end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_backpressure();
    test_overflow();
    test_reads();
    test_rd_done_coincide();
    test_reset_mid_body();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
